// File: rtl/bsg_down_pkg.sv
// Shared types and constants for the BSG downstream channel.
// Used by the IO ingress stage and the core-side read/output stages.
package bsg_down_pkg;

  localparam int DEPTH_LG    = 6;
  localparam int IO_W        = 8;
  localparam int WORD_W      = 16;
  localparam int TOKEN_WORDS = 4;
  localparam int TOK_LG      = (TOKEN_WORDS > 1) ? $clog2(TOKEN_WORDS) : 1;

  typedef logic [DEPTH_LG:0]   ptr_t;
  typedef logic [DEPTH_LG-1:0] addr_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [IO_W-1:0]     byte_t;

  // Full when wrap bits differ and the entry indices match.
  function automatic logic ptr_full(ptr_t w, ptr_t r);
    return (w[DEPTH_LG] != r[DEPTH_LG]) &&
           (w[DEPTH_LG-1:0] == r[DEPTH_LG-1:0]);
  endfunction

endpackage

// File: rtl/bsg_down_token_counter.sv
// Credit return: one token pulse per TOKEN_WORDS read-pointer advances.
// The advance is detected against a registered copy of rptr.
module bsg_down_token_counter
  import bsg_down_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  ptr_t rptr,
  output logic io_token_out
);

  ptr_t              rptr_q;
  logic [TOK_LG-1:0] tok_cnt;
  logic              adv;

  assign adv = (rptr != rptr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q       <= '0;
      tok_cnt      <= '0;
      io_token_out <= 1'b0;
    end else begin
      rptr_q       <= rptr;
      io_token_out <= 1'b0;
      if (adv) begin
        if (tok_cnt == TOK_LG'(TOKEN_WORDS - 1)) begin
          tok_cnt      <= '0;
          io_token_out <= 1'b1;
        end else begin
          tok_cnt <= tok_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bsg_down_io_ingress.sv
// IO-side write stage: packs byte pairs into words and fills the
// channel buffer, publishing wptr/wptr_t and returning credits.
module bsg_down_io_ingress
  import bsg_down_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  io_valid_in,
  input  byte_t io_data_in,
  input  ptr_t  rptr,
  output logic  buf_we,
  output addr_t buf_waddr,
  output word_t buf_wdata,
  output ptr_t  wptr,
  output ptr_t  wptr_t,
  output logic  full,
  output logic  io_token_out,
  output logic  overflow_err
);

  logic  io_valid;
  byte_t io_data;
  logic  half;
  byte_t low_byte;

  assign full = ptr_full(wptr, rptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      io_valid <= 1'b0;
      io_data  <= '0;
    end else begin
      io_valid <= io_valid_in;
      io_data  <= io_data_in;
    end
  end

  // wptr moves on the write edge so full never misses an in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      half         <= 1'b0;
      low_byte     <= '0;
      buf_we       <= 1'b0;
      buf_waddr    <= '0;
      buf_wdata    <= '0;
      wptr         <= '0;
      wptr_t       <= '0;
      overflow_err <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      wptr_t <= wptr;
      if (io_valid) begin
        if (!half) begin
          low_byte <= io_data;
          half     <= 1'b1;
        end else begin
          half <= 1'b0;
          if (!full) begin
            buf_we    <= 1'b1;
            buf_waddr <= wptr[DEPTH_LG-1:0];
            buf_wdata <= {io_data, low_byte};
            wptr      <= wptr + 1'b1;
          end else begin
            overflow_err <= 1'b1;
          end
        end
      end
    end
  end

  bsg_down_token_counter u_tok (
    .clk          (clk),
    .rst          (rst),
    .rptr         (rptr),
    .io_token_out (io_token_out)
  );

endmodule
